// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered long-latency results onto the reg_file write port.
// Latency: ALU 1 cycle to reg_write; long-latency 2 cycles (push edge, then pop edge) when the FIFO is empty and the ALU is idle.
// Backpressure: ALU is never stalled and has fixed priority; the long-latency channel is held off with m_ready while the FIFO is full.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   a_valid/a_rd/a_data        ALU result stream (always accepted)
//   m_valid/m_ready/m_rd/m_data long-latency result channel (valid/ready)
//   reg_write/rd/write_data    registered reg_file write port
//   pending                    per-register bitmap of destinations still queued in the FIFO
//   fifo_count                 number of occupied FIFO entries
module wb_write_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending,
  output logic [CW-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic fifo_full;
  logic fifo_empty;
  logic alu_sel;
  logic push;
  logic pop;

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Ready depends only on occupancy and reset, never on m_valid.
  assign m_ready = reset && !fifo_full;

  // A write to x0 is architecturally a no-op, so it is treated as no request.
  assign alu_sel = a_valid && (a_rd != 5'd0);
  assign push    = m_valid && m_ready && (m_rd != 5'd0);
  assign pop     = !alu_sel && !fifo_empty;

  // Entry storage needs no reset: only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= m_rd;
      mem_data[wr_ptr] <= m_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (alu_sel) begin
      reg_write  <= 1'b1;
      rd         <= a_rd;
      write_data <= a_data;
    end else if (pop) begin
      reg_write  <= 1'b1;
      rd         <= mem_rd[rd_ptr];
      write_data <= mem_data[rd_ptr];
    end else begin
      // rd/write_data hold so the write port does not toggle on idle cycles.
      reg_write  <= 1'b0;
    end
  end

  // An entry is occupied when its distance from the head is below the count;
  // the bit drops on the same edge that moves the entry onto reg_write.
  always_comb begin
    logic [AW-1:0] off;
    pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < fifo_count) pending[mem_rd[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic            reg_write;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic [31:0]     pending;
  logic [CW-1:0]   fifo_count;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wb_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_rd       (m_rd),
    .m_data     (m_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [XLEN-1:0] d);
    wr_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rd, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", 64'(rd), 64'(e.rd));
        check("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    a_valid = 1'b0;
    a_rd    = '0;
    a_data  = '0;
    m_valid = 1'b0;
    m_rd    = '0;
    m_data  = '0;

    // Power-on reset state.
    repeat (2) step();
    check("por_reg_write", 64'(reg_write), 64'd0);
    check("por_rd", 64'(rd), 64'd0);
    check("por_write_data", write_data, 64'd0);
    check("por_fifo_count", 64'(fifo_count), 64'd0);
    check("por_pending", 64'(pending), 64'd0);
    check("por_m_ready", 64'(m_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("por_release_m_ready", 64'(m_ready), 64'd1);

    // Reset mid-traffic: ALU busy so three pushes stay queued, then reset.
    a_valid = 1'b1; a_rd = 5'd7; a_data = 64'h77;
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'b1; m_rd = 5'(i + 1); m_data = 64'h100 + 64'(i);
      expect_wr(5'd7, 64'h77);
      step();
    end
    m_valid = 1'b0;
    step();
    check("mid_fifo_count", 64'(fifo_count), 64'd3);
    check("mid_pending", 64'(pending), 64'h0000_000E);
    // The ALU write loaded on the last edge is killed by reset before the monitor samples.
    reset   = 1'b0;
    a_valid = 1'b0;
    #1;
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    repeat (2) step();
    check("rst_hold_m_ready", 64'(m_ready), 64'd0);
    check("rst_hold_reg_write", 64'(reg_write), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_release_m_ready", 64'(m_ready), 64'd1);
    step();

    // ALU path: one cycle latency, then idle.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1005;
    expect_wr(5'd5, 64'h1005);
    step();
    a_valid = 1'b0;
    check("alu_reg_write", 64'(reg_write), 64'd1);
    check("alu_rd", 64'(rd), 64'd5);
    check("alu_data", write_data, 64'h1005);
    step();
    check("alu_idle_reg_write", 64'(reg_write), 64'd0);

    // x0 suppression on both paths.
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    a_valid = 1'b0;
    check("x0_alu_reg_write", 64'(reg_write), 64'd0);
    m_valid = 1'b1; m_rd = 5'd0; m_data = 64'hDEAD;
    check("x0_m_handshake", 64'(m_ready), 64'd1);
    step();
    m_valid = 1'b0;
    check("x0_fifo_count", 64'(fifo_count), 64'd0);
    step();
    check("x0_m_reg_write", 64'(reg_write), 64'd0);
    check("x0_pending", 64'(pending), 64'd0);

    // Priority and order: x3, x3, x1, x2.
    expect_wr(5'd3, 64'h1003);
    expect_wr(5'd3, 64'h1003);
    expect_wr(5'd1, 64'h1001);
    expect_wr(5'd2, 64'h1002);
    m_valid = 1'b1; m_rd = 5'd1; m_data = 64'h1001;
    step();
    m_rd = 5'd2; m_data = 64'h1002;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h1003;
    step();
    m_valid = 1'b0;
    check("prio_pending_a", 64'(pending), 64'h6);
    step();
    a_valid = 1'b0;
    check("prio_pending_b", 64'(pending), 64'h6);
    step();
    check("prio_pending_c", 64'(pending), 64'h4);
    step();
    check("prio_pending_d", 64'(pending), 64'h0);
    check("prio_count_d", 64'(fifo_count), 64'd0);
    step();

    // Full / backpressure with the ALU busy.
    a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h900;
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1; m_rd = 5'(10 + i); m_data = 64'h2000 + 64'(i);
      check("full_ready_pre", 64'(m_ready), 64'd1);
      expect_wr(5'd9, 64'h900);
      step();
    end
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_ready", 64'(m_ready), 64'd0);
    m_rd = 5'd14; m_data = 64'h2004;
    expect_wr(5'd9, 64'h900);
    step();
    check("full_wait_count", 64'(fifo_count), 64'd4);
    check("full_wait_ready", 64'(m_ready), 64'd0);
    for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 64'h2000 + 64'(i));
    a_valid = 1'b0;
    step();
    check("full_pop_count", 64'(fifo_count), 64'd3);
    check("full_pop_ready", 64'(m_ready), 64'd1);
    step();
    m_valid = 1'b0;
    check("full_fifth_count", 64'(fifo_count), 64'd3);
    repeat (3) step();
    check("full_drain_count", 64'(fifo_count), 64'd0);
    step();

    // Wrap-around: back-to-back pushes with concurrent pops.
    for (int i = 0; i < 12; i++) begin
      m_valid = 1'b1; m_rd = 5'(i + 1); m_data = 64'h3000 + 64'(i);
      expect_wr(5'(i + 1), 64'h3000 + 64'(i));
      check("wrap_ready", 64'(m_ready), 64'd1);
      step();
      check("wrap_count", 64'(fifo_count), 64'd1);
    end
    m_valid = 1'b0;
    repeat (3) step();
    check("wrap_drain_count", 64'(fifo_count), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
